// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
// Deglitches ps2c, detects its falling edges, and shifts in 11-bit frames
// (start, 8 data bits LSB first, odd parity, stop). Each frame is checked
// and reported as a good scan byte or a classified error. A watchdog
// discards frames whose clock stalls.
module ps2_frame_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned TW          = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       err_tick,
    output logic [1:0] err_code,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DPS  = 2'b01,
        ST_CHK  = 2'b10
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_FRAMING = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    // ------------------------------------------------------------------
    // ps2c deglitch filter and falling-edge detect
    // ------------------------------------------------------------------
    logic [FILTER_LEN-1:0] filt_reg;
    logic [FILTER_LEN-1:0] filt_next;
    logic                  f_val_reg;
    logic                  f_val_next;
    logic                  fall;

    // Filtered level only changes once the whole window agrees.
    always_comb begin
        filt_next  = {ps2c, filt_reg[FILTER_LEN-1:1]};
        f_val_next = f_val_reg;
        if (filt_next == '1) begin
            f_val_next = 1'b1;
        end else if (filt_next == '0) begin
            f_val_next = 1'b0;
        end
        fall = f_val_reg & ~f_val_next;
    end

    // Filter shift register and filtered clock level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_reg  <= '1;
            f_val_reg <= 1'b1;
        end else begin
            filt_reg  <= filt_next;
            f_val_reg <= f_val_next;
        end
    end

    // ------------------------------------------------------------------
    // ps2d synchroniser
    // ------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic       data_bit;

    // Two-flop synchroniser for the asynchronous data line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[0], ps2d};
        end
    end

    assign data_bit = sync_reg[1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t          state_reg;
    state_t          state_next;
    logic [3:0]      n_reg;
    logic [3:0]      n_next;
    logic [TW-1:0]   timer_reg;
    logic [TW-1:0]   timer_next;
    logic [10:0]     b_reg;
    logic [10:0]     b_next;
    logic [7:0]      dout_reg;
    logic [7:0]      dout_next;
    logic [1:0]      err_reg;
    logic [1:0]      err_next;
    logic            framing_bad;
    logic            parity_bad;

    // Frame layout once fully shifted: b[0] start, b[8:1] data,
    // b[9] parity, b[10] stop.
    assign framing_bad = (b_reg[0] != 1'b0) || (b_reg[10] != 1'b1);
    assign parity_bad  = ~(^b_reg[9:1]);

    // State, bit counter, watchdog timer, shift register and result holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            n_reg     <= '0;
            timer_reg <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            err_reg   <= ERR_NONE;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            timer_reg <= timer_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic, tick generation and result updates.
    always_comb begin
        state_next   = state_reg;
        n_next       = n_reg;
        timer_next   = timer_reg;
        b_next       = b_reg;
        dout_next    = dout_reg;
        err_next     = err_reg;
        rx_done_tick = 1'b0;
        err_tick     = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (fall && rx_en) begin
                    b_next     = {data_bit, b_reg[10:1]};
                    n_next     = 4'd9;
                    timer_next = '0;
                    state_next = ST_DPS;
                end
            end

            ST_DPS: begin
                if (fall) begin
                    b_next     = {data_bit, b_reg[10:1]};
                    timer_next = '0;
                    if (n_reg == 4'd0) begin
                        state_next = ST_CHK;
                    end else begin
                        n_next = n_reg - 4'd1;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = ST_IDLE;
                    err_tick   = 1'b1;
                    err_next   = ERR_TIMEOUT;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            ST_CHK: begin
                state_next = ST_IDLE;
                if (framing_bad) begin
                    err_tick = 1'b1;
                    err_next = ERR_FRAMING;
                end else if (parity_bad) begin
                    err_tick = 1'b1;
                    err_next = ERR_PARITY;
                end else begin
                    rx_done_tick = 1'b1;
                    dout_next    = b_reg[8:1];
                    err_next     = ERR_NONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Results are shown from the tick cycle onward and held by the
    // registers afterwards, so the consumer sees dout with rx_done_tick.
    assign dout     = dout_next;
    assign err_code = err_next;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed and randomized PS/2
// frames checked against a frame-level reference model.
module tb_ps2_frame_rx;

    localparam int FL  = 8;
    localparam int TO  = 600;
    localparam int TWB = 10;

    logic       clk;
    logic       reset;
    logic       ps2d;
    logic       ps2c;
    logic       rx_en;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       err_tick;
    logic [1:0] err_code;
    logic       busy;

    ps2_frame_rx #(
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TO),
        .TW         (TWB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2d        (ps2d),
        .ps2c        (ps2c),
        .rx_en       (rx_en),
        .dout        (dout),
        .rx_done_tick(rx_done_tick),
        .err_tick    (err_tick),
        .err_code    (err_code),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    int         done_cyc  = 0;
    int         err_cyc   = 0;
    logic [7:0] done_dout = '0;
    logic [1:0] err_cap   = '0;
    logic       busy_seen = 1'b0;
    logic [7:0] prev_dout = '0;

    // Reference model state
    logic [7:0] exp_dout = '0;
    logic [1:0] exp_code = '0;
    int         low_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame classification from the protocol rules: 0 good, 1 parity, 2 framing.
    function automatic int classify(input logic [10:0] f);
        if (f[0] !== 1'b0 || f[10] !== 1'b1) return 2;
        if (($countones(f[9:1]) % 2) != 1) return 1;
        return 0;
    endfunction

    function automatic logic [10:0] mk(input logic [7:0] d, input logic st, input logic par, input logic sp);
        return {sp, par, d, st};
    endfunction

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    // Observe ticks, results and hold behaviour between the clock edges.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_done_tick) begin
                done_cnt++;
                done_cyc  = cyc;
                done_dout = dout;
            end
            if (err_tick) begin
                err_cnt++;
                err_cyc = cyc;
                err_cap = err_code;
            end
            if (rx_done_tick || err_tick)
                check("tick_exclusive", 32'(rx_done_tick & err_tick), 32'd0);
            if (dout !== prev_dout)
                check("dout_change_only_on_done", 32'(rx_done_tick), 32'd1);
            if (busy) busy_seen = 1'b1;
        end
        prev_dout = dout;
    end

    task automatic send_bits(input logic [10:0] f, input int nb, input int half);
        for (int i = 0; i < nb; i++) begin
            @(posedge clk); #1;
            ps2d = f[i];
            repeat (half) @(posedge clk);
            #1;
            ps2c    = 1'b0;
            low_cyc = cyc;
            repeat (half) @(posedge clk);
            #1;
            ps2c = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [10:0] f, input int half);
        int d0;
        int e0;
        int k;
        int lat;
        d0 = done_cnt;
        e0 = err_cnt;
        send_bits(f, 11, half);
        k = classify(f);
        if (k == 0) begin
            exp_dout = f[8:1];
            exp_code = 2'b00;
        end else begin
            exp_code = (k == 1) ? 2'b01 : 2'b10;
        end
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), (k == 0) ? 32'd1 : 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt - e0), (k == 0) ? 32'd0 : 32'd1);
        if (k == 0) begin
            check({tag, "_dout_at_tick"}, 32'(done_dout), 32'(exp_dout));
            lat = done_cyc - low_cyc;
        end else begin
            check({tag, "_code_at_tick"}, 32'(err_cap), 32'(exp_code));
            lat = err_cyc - low_cyc;
        end
        check({tag, "_latency_ok"}, 32'(lat >= FL && lat <= FL + 1), 32'd1);
        check({tag, "_dout_held"}, 32'(dout), 32'(exp_dout));
        check({tag, "_code_held"}, 32'(err_code), 32'(exp_code));
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        int got;
        int lat;
        logic [7:0]  rd;
        logic [10:0] rf;
        int          kind;

        reset = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rx_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_code", 32'(err_code), 32'd0);
        check("rst_done", 32'(rx_done_tick), 32'd0);
        check("rst_err", 32'(err_tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Parity error right after reset: dout keeps 0x00
        run_frame("par_err", mk(8'h1C, 1'b0, 1'b1, 1'b1), 40);
        // Good 0x1C
        run_frame("good_1c", mk(8'h1C, 1'b0, 1'b0, 1'b1), 40);
        // Framing: bad stop, then bad start
        run_frame("bad_stop", mk(8'hF0, 1'b0, odd_par(8'hF0), 1'b0), 30);
        run_frame("bad_start", mk(8'hF0, 1'b1, odd_par(8'hF0), 1'b1), 30);

        // Timeout after 5 bits
        d0 = done_cnt;
        e0 = err_cnt;
        send_bits(mk(8'h77, 1'b0, odd_par(8'h77), 1'b1), 5, 25);
        got = 0;
        for (int i = 0; i < TO + 200; i++) begin
            @(posedge clk);
            if (err_cnt != e0) begin
                got = 1;
                break;
            end
        end
        check("to_seen", 32'(got), 32'd1);
        check("to_code", 32'(err_cap), 32'd3);
        lat = err_cyc - low_cyc;
        check("to_latency_ok", 32'(lat >= TO + FL - 2 && lat <= TO + FL + 1), 32'd1);
        @(negedge clk);
        check("to_busy_drop", 32'(busy), 32'd0);
        check("to_no_done", 32'(done_cnt - d0), 32'd0);
        exp_code = 2'b11;
        check("to_code_held", 32'(err_code), 32'(exp_code));
        @(posedge clk); #1;
        run_frame("good_5a", mk(8'h5A, 1'b0, odd_par(8'h5A), 1'b1), 35);

        // Short ps2c glitches in idle
        d0 = done_cnt;
        e0 = err_cnt;
        busy_seen = 1'b0;
        @(posedge clk); #1;
        ps2c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ps2c = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        ps2c = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        ps2c = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("glitch_busy", 32'(busy_seen), 32'd0);
        check("glitch_ticks", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        // rx_en low for a whole frame: ignored
        rx_en = 1'b0;
        send_bits(mk(8'h33, 1'b0, odd_par(8'h33), 1'b1), 11, 30);
        check("rxen0_busy", 32'(busy_seen), 32'd0);
        check("rxen0_ticks", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        check("rxen0_dout", 32'(dout), 32'(exp_dout));
        rx_en = 1'b1;
        run_frame("rxen1_44", mk(8'h44, 1'b0, odd_par(8'h44), 1'b1), 30);

        // Randomized frames, some with injected errors
        for (int n = 0; n < 16; n++) begin
            rd   = 8'($urandom);
            kind = int'($urandom_range(0, 3));
            case (kind)
                1:       rf = mk(rd, 1'b0, ~odd_par(rd), 1'b1);
                2:       rf = mk(rd, 1'b0, 1'($urandom), 1'b0);
                3:       rf = mk(rd, 1'b1, 1'($urandom), 1'($urandom));
                default: rf = mk(rd, 1'b0, odd_par(rd), 1'b1);
            endcase
            run_frame("rand", rf, int'($urandom_range(2 * FL + 4, 50)));
        end

        // Reset in the middle of a frame
        send_bits(mk(8'h29, 1'b0, odd_par(8'h29), 1'b1), 6, 25);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_dout", 32'(dout), 32'h00);
        check("mid_rst_code", 32'(err_code), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ticks", 32'(rx_done_tick | err_tick), 32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        exp_dout = '0;
        exp_code = '0;
        repeat (3) @(posedge clk);
        #1;
        run_frame("after_rst_29", mk(8'h29, 1'b0, odd_par(8'h29), 1'b1), 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
